// File: rtl/oam_dma.sv
// Sprite DMA engine: stalls the core and copies one page to the PPU OAM data port.
// Optional `OAM_DMA_PARITY_EN` inserts an ALIGN cycle so every READ lands on an even cycle.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int          XFER_LEN  = 256
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic        O_cpu_ready,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] latch;
  logic       cpu_ready;
  logic       busy;

`ifdef OAM_DMA_PARITY_EN
  logic parity;

  always_ff @(posedge I_clock) begin
    if (!I_reset) parity <= 1'b0;
    else          parity <= ~parity;
  end
`endif

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      state     <= IDLE;
      page      <= 8'h00;
      index     <= 8'h00;
      latch     <= 8'h00;
      cpu_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_cpu_addr == TRIG_ADDR && !I_cpu_rdwr) begin
            page      <= I_cpu_wr_data;
            index     <= 8'h00;
            state     <= HALT;
            cpu_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        // The core only honours ready on reads, so wait out any write cycles.
        HALT: begin
          if (I_cpu_rdwr) begin
`ifdef OAM_DMA_PARITY_EN
            state <= parity ? READ : ALIGN;
`else
            state <= READ;
`endif
          end
        end
        ALIGN: state <= READ;
        READ: begin
          latch <= I_rd_data;
          state <= WRITE;
        end
        WRITE: begin
          index <= index + 8'd1;
          if (index == LAST_INDEX) begin
            state     <= IDLE;
            cpu_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    O_addr    = I_cpu_addr;
    O_wr_data = I_cpu_wr_data;
    O_rdwr    = I_cpu_rdwr;
    case (state)
      ALIGN: O_rdwr = 1'b1;
      READ: begin
        O_addr = {page, index};
        O_rdwr = 1'b1;
      end
      WRITE: begin
        O_addr    = DEST_ADDR;
        O_wr_data = latch;
        O_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

  assign O_cpu_ready = cpu_ready;
  assign O_busy      = busy;

endmodule
